// File: rtl/tdp_ram_ctl.sv
// tdp_ram_ctl: true-dual-port RAM with post-reset clear, read-during-write modes, optional output register, write collision flag
// clk/rst: clock and asynchronous active-high reset
// en_x/we_x/addr_x/data_x: port x access enable, write enable, address, write data
// q_x/valid_x: port x read data and its valid strobe
// busy: clear sequence running; collision: last cycle both ports wrote one address
module tdp_ram_ctl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6,
   parameter int RDW_MODE = 0,
   parameter int OUT_REG = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_a,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] data_a,
   output logic [DATA_W-1:0] q_a,
   output logic              valid_a,
   input  logic              en_b,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] data_b,
   output logic [DATA_W-1:0] q_b,
   output logic              valid_b,
   output logic              busy,
   output logic              collision
);
   localparam int DEPTH = 2 ** ADDR_W;
   typedef enum logic {CLEAR, RUN} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] s1_a, s1_b;
   logic v1_a, v1_b, wr_a, wr_b, wr_b_req, acc_a, acc_b;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      else state <= state_nx;
   always_comb state_nx = (state == CLEAR && &cnt) ? RUN : state;
   // no-change mode suppresses the stage-1 update (and its valid) on writes
   always_comb begin
      busy = (state == CLEAR);
      wr_a = !busy && en_a && we_a;
      wr_b_req = !busy && en_b && we_b;
      wr_b = wr_b_req && !(wr_a && addr_a == addr_b);
      acc_a = !busy && en_a && (!we_a || RDW_MODE != 2);
      acc_b = !busy && en_b && (!we_b || RDW_MODE != 2);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (busy) cnt <= cnt + 1'b1;
   // port A wins a same-address double write
   always_ff @(posedge clk)
      if (busy) mem[cnt] <= '0;
      else begin
         if (wr_a) mem[addr_a] <= data_a;
         if (wr_b) mem[addr_b] <= data_b;
      end
   // mem reads here see pre-edge contents: read-first and cross-port old data fall out naturally
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1_a <= '0;
         s1_b <= '0;
         v1_a <= 1'b0;
         v1_b <= 1'b0;
         collision <= 1'b0;
      end else begin
         v1_a <= acc_a;
         v1_b <= acc_b;
         if (acc_a) s1_a <= (we_a && RDW_MODE == 0) ? data_a : mem[addr_a];
         if (acc_b) s1_b <= (we_b && RDW_MODE == 0) ? data_b : mem[addr_b];
         collision <= wr_a && wr_b_req && addr_a == addr_b;
      end
   if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            q_a <= '0;
            q_b <= '0;
            valid_a <= 1'b0;
            valid_b <= 1'b0;
         end else begin
            q_a <= s1_a;
            q_b <= s1_b;
            valid_a <= v1_a;
            valid_b <= v1_b;
         end
   end else begin : g_noreg
      always_comb begin
         q_a = s1_a;
         q_b = s1_b;
         valid_a = v1_a;
         valid_b = v1_b;
      end
   end
endmodule

// File: tb/tb_tdp_ram_ctl.sv
// tb_tdp_ram_ctl: randomized check of three tdp_ram_ctl configurations against a behavioural memory model
module tb_tdp_ram_ctl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en[2], we[2];
   logic [5:0] ad[2];
   logic [7:0] dt[2];
   logic [7:0] q_o[3][2];
   logic v_o[3][2];
   logic busy_o[3], coll_o[3];
   int checks = 0;
   int errors = 0;
   logic [7:0] mm[64];
   int clr_left;
   logic [7:0] s1q[3][2], eq[3][2];
   bit s1v[3][2], ev[3][2];
   bit ecoll;
   always #5 clk = ~clk;
   // instance i uses RDW_MODE = i; instance 1 also has the output register
   tdp_ram_ctl #(.RDW_MODE(0), .OUT_REG(0)) dut0 (.clk(clk), .rst(rst),
      .en_a(en[0]), .we_a(we[0]), .addr_a(ad[0]), .data_a(dt[0]), .q_a(q_o[0][0]), .valid_a(v_o[0][0]),
      .en_b(en[1]), .we_b(we[1]), .addr_b(ad[1]), .data_b(dt[1]), .q_b(q_o[0][1]), .valid_b(v_o[0][1]),
      .busy(busy_o[0]), .collision(coll_o[0]));
   tdp_ram_ctl #(.RDW_MODE(1), .OUT_REG(1)) dut1 (.clk(clk), .rst(rst),
      .en_a(en[0]), .we_a(we[0]), .addr_a(ad[0]), .data_a(dt[0]), .q_a(q_o[1][0]), .valid_a(v_o[1][0]),
      .en_b(en[1]), .we_b(we[1]), .addr_b(ad[1]), .data_b(dt[1]), .q_b(q_o[1][1]), .valid_b(v_o[1][1]),
      .busy(busy_o[1]), .collision(coll_o[1]));
   tdp_ram_ctl #(.RDW_MODE(2), .OUT_REG(0)) dut2 (.clk(clk), .rst(rst),
      .en_a(en[0]), .we_a(we[0]), .addr_a(ad[0]), .data_a(dt[0]), .q_a(q_o[2][0]), .valid_a(v_o[2][0]),
      .en_b(en[1]), .we_b(we[1]), .addr_b(ad[1]), .data_b(dt[1]), .q_b(q_o[2][1]), .valid_b(v_o[2][1]),
      .busy(busy_o[2]), .collision(coll_o[2]));
   task automatic model_reset();
      for (int i = 0; i < 3; i++)
         for (int p = 0; p < 2; p++) begin
            s1q[i][p] = '0;
            s1v[i][p] = 1'b0;
            eq[i][p] = '0;
            ev[i][p] = 1'b0;
         end
      ecoll = 1'b0;
      clr_left = 64;
   endtask
   task automatic drive(input bit ea, input bit wa, input logic [5:0] aa, input logic [7:0] da,
                        input bit eb, input bit wb, input logic [5:0] ab, input logic [7:0] db);
      bit e[2], w[2];
      logic [5:0] a[2];
      logic [7:0] d[2], old[2];
      e = '{ea, eb};
      w = '{wa, wb};
      a = '{aa, ab};
      d = '{da, db};
      for (int p = 0; p < 2; p++) begin
         en[p] = e[p];
         we[p] = w[p];
         ad[p] = a[p];
         dt[p] = d[p];
         eq[1][p] = s1q[1][p];
         ev[1][p] = s1v[1][p];
      end
      if (clr_left > 0) begin
         mm[6'(64 - clr_left)] = '0;
         clr_left--;
         for (int i = 0; i < 3; i++)
            for (int p = 0; p < 2; p++) s1v[i][p] = 1'b0;
         ecoll = 1'b0;
      end else begin
         for (int p = 0; p < 2; p++) old[p] = mm[a[p]];
         for (int i = 0; i < 3; i++)
            for (int p = 0; p < 2; p++)
               if (!e[p]) s1v[i][p] = 1'b0;
               else if (!w[p]) begin
                  s1q[i][p] = old[p];
                  s1v[i][p] = 1'b1;
               end else begin
                  s1v[i][p] = (i != 2);
                  if (i == 0) s1q[i][p] = d[p];
                  if (i == 1) s1q[i][p] = old[p];
               end
         ecoll = e[0] && w[0] && e[1] && w[1] && a[0] == a[1];
         if (e[0] && w[0]) mm[a[0]] = d[0];
         if (e[1] && w[1] && !ecoll) mm[a[1]] = d[1];
      end
      for (int p = 0; p < 2; p++) begin
         eq[0][p] = s1q[0][p];
         ev[0][p] = s1v[0][p];
         eq[2][p] = s1q[2][p];
         ev[2][p] = s1v[2][p];
      end
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic test_reset();
      model_reset();
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (busy_o[i] !== 1'b1 || coll_o[i] !== 1'b0 || q_o[i][0] !== 8'h00 || q_o[i][1] !== 8'h00 ||
             v_o[i][0] !== 1'b0 || v_o[i][1] !== 1'b0) begin
            errors++;
            $display("FAIL reset dut%0d busy=%b coll=%b q=%h/%h v=%b/%b want busy=1 rest 0", i,
                     busy_o[i], coll_o[i], q_o[i][0], q_o[i][1], v_o[i][0], v_o[i][1]);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask
   task automatic test_clear();
      int busy_cycles = 0;
      for (int c = 0; c < 64; c++) begin
         idle();
         if (busy_o[0] === 1'b1) busy_cycles++;
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy_o[i] !== (clr_left > 0) || v_o[i][0] !== 1'b0 || v_o[i][1] !== 1'b0) begin
               errors++;
               $display("FAIL clear_busy dut%0d cyc%0d busy=%b v=%b/%b want busy=%b v=0/0", i, c,
                        busy_o[i], v_o[i][0], v_o[i][1], clr_left > 0);
            end
         end
      end
      checks++;
      if (busy_cycles != 63) begin
         errors++;
         $display("FAIL clear_len busy seen for %0d of 64 edges, want 63 (drops on the 64th)", busy_cycles);
      end
      foreach (ad[k]) ad[k] = '0;
      for (int k = 0; k < 3; k++) begin
         logic [5:0] adr;
         adr = (k == 0) ? 6'd0 : (k == 1) ? 6'd31 : 6'd63;
         drive(1, 0, adr, 8'hFF, 0, 0, 0, 0);
         checks++;
         if (q_o[0][0] !== 8'h00 || v_o[0][0] !== 1'b1) begin
            errors++;
            $display("FAIL clear_read addr%0d q=%h v=%b want 00/1", adr, q_o[0][0], v_o[0][0]);
         end
      end
   endtask
   task automatic test_latency();
      drive(1, 1, 6'd5, 8'hA5, 0, 0, 0, 0);
      drive(1, 0, 6'd5, 8'h00, 0, 0, 0, 0);
      checks++;
      if (q_o[0][0] !== 8'hA5 || v_o[0][0] !== 1'b1) begin
         errors++;
         $display("FAIL lat1 q=%h v=%b want a5/1", q_o[0][0], v_o[0][0]);
      end
      checks++;
      if (q_o[1][0] !== 8'h00 || v_o[1][0] !== 1'b1) begin
         errors++;
         $display("FAIL lat2_early q=%h v=%b want 00/1 (read-first write result)", q_o[1][0], v_o[1][0]);
      end
      idle();
      checks++;
      if (q_o[1][0] !== 8'hA5 || v_o[1][0] !== 1'b1 || v_o[0][0] !== 1'b0) begin
         errors++;
         $display("FAIL lat2 q=%h v=%b v0=%b want a5/1/0", q_o[1][0], v_o[1][0], v_o[0][0]);
      end
   endtask
   task automatic test_rdw();
      drive(1, 1, 6'd9, 8'h11, 0, 0, 0, 0);
      drive(1, 1, 6'd9, 8'h22, 0, 0, 0, 0);
      checks++;
      if (q_o[0][0] !== 8'h22 || v_o[0][0] !== 1'b1) begin
         errors++;
         $display("FAIL rdw0 q=%h v=%b want 22/1", q_o[0][0], v_o[0][0]);
      end
      checks++;
      if (q_o[2][0] !== 8'hA5 || v_o[2][0] !== 1'b0) begin
         errors++;
         $display("FAIL rdw2 q=%h v=%b want a5/0", q_o[2][0], v_o[2][0]);
      end
      drive(1, 0, 6'd9, 8'h00, 0, 0, 0, 0);
      checks++;
      if (q_o[1][0] !== 8'h11 || v_o[1][0] !== 1'b1) begin
         errors++;
         $display("FAIL rdw1 q=%h v=%b want 11/1", q_o[1][0], v_o[1][0]);
      end
      checks++;
      if (q_o[0][0] !== 8'h22 || q_o[2][0] !== 8'h22 || v_o[2][0] !== 1'b1) begin
         errors++;
         $display("FAIL rdw_read q0=%h q2=%h v2=%b want 22/22/1", q_o[0][0], q_o[2][0], v_o[2][0]);
      end
      idle();
      checks++;
      if (q_o[1][0] !== 8'h22) begin
         errors++;
         $display("FAIL rdw_read1 q=%h want 22", q_o[1][0]);
      end
   endtask
   task automatic test_cross();
      drive(1, 1, 6'd3, 8'h10, 0, 0, 0, 0);
      drive(1, 1, 6'd3, 8'h20, 1, 0, 6'd3, 8'h00);
      checks++;
      if (q_o[0][1] !== 8'h10 || q_o[2][1] !== 8'h10 || v_o[0][1] !== 1'b1) begin
         errors++;
         $display("FAIL cross_old q0=%h q2=%h v=%b want 10/10/1", q_o[0][1], q_o[2][1], v_o[0][1]);
      end
      drive(0, 0, 0, 0, 1, 0, 6'd3, 8'h00);
      checks++;
      if (q_o[0][1] !== 8'h20) begin
         errors++;
         $display("FAIL cross_new q=%h want 20", q_o[0][1]);
      end
   endtask
   task automatic test_collision();
      drive(1, 1, 6'd12, 8'hAA, 1, 1, 6'd12, 8'h55);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (coll_o[i] !== 1'b1) begin
            errors++;
            $display("FAIL coll_pulse dut%0d coll=%b want 1", i, coll_o[i]);
         end
      end
      checks++;
      if (q_o[0][1] !== 8'h55) begin
         errors++;
         $display("FAIL coll_wf q_b=%h want 55", q_o[0][1]);
      end
      drive(1, 0, 6'd12, 8'h00, 0, 0, 0, 0);
      checks++;
      if (coll_o[0] !== 1'b0 || q_o[0][0] !== 8'hAA) begin
         errors++;
         $display("FAIL coll_after coll=%b q=%h want 0/aa", coll_o[0], q_o[0][0]);
      end
   endtask
   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive(1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)), 8'($urandom),
               1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)), 8'($urandom));
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (coll_o[i] !== ecoll || busy_o[i] !== 1'b0) begin
               errors++;
               $display("FAIL rand_flags dut%0d cyc%0d coll=%b busy=%b want %b/0", i, c, coll_o[i], busy_o[i], ecoll);
            end
            for (int p = 0; p < 2; p++) begin
               checks++;
               if (v_o[i][p] !== ev[i][p] || (ev[i][p] && q_o[i][p] !== eq[i][p])) begin
                  errors++;
                  $display("FAIL rand_q dut%0d port%0d cyc%0d q=%h v=%b want %h/%b", i, p, c,
                           q_o[i][p], v_o[i][p], eq[i][p], ev[i][p]);
               end
            end
         end
      end
   endtask
   task automatic test_reset_mid_clear();
      int busy_cycles = 0;
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 20; c++)
         drive(1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom));
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (busy_o[0] !== 1'b1 || q_o[0][0] !== 8'h00 || v_o[0][0] !== 1'b0) begin
         errors++;
         $display("FAIL midclr_rst busy=%b q=%h v=%b want 1/00/0", busy_o[0], q_o[0][0], v_o[0][0]);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 64; c++) begin
         drive(1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom));
         if (busy_o[0] === 1'b1) busy_cycles++;
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy_o[i] !== (clr_left > 0) || q_o[i][0] !== 8'h00 || q_o[i][1] !== 8'h00 ||
                v_o[i][0] !== 1'b0 || v_o[i][1] !== 1'b0) begin
               errors++;
               $display("FAIL midclr_run dut%0d cyc%0d busy=%b q=%h/%h v=%b/%b want busy=%b rest 0", i, c,
                        busy_o[i], q_o[i][0], q_o[i][1], v_o[i][0], v_o[i][1], clr_left > 0);
            end
         end
      end
      checks++;
      if (busy_cycles != 63) begin
         errors++;
         $display("FAIL midclr_len busy seen for %0d of 64 edges, want 63", busy_cycles);
      end
      for (int k = 0; k < 32; k++) begin
         drive(1, 0, 6'(2 * k), 8'h00, 1, 0, 6'(2 * k + 1), 8'h00);
         for (int p = 0; p < 2; p++) begin
            checks++;
            if (q_o[0][p] !== 8'h00 || q_o[2][p] !== 8'h00 || v_o[0][p] !== 1'b1 || eq[0][p] !== 8'h00) begin
               errors++;
               $display("FAIL midclr_zero addr%0d q0=%h q2=%h v=%b want 00/00/1", 2 * k + p,
                        q_o[0][p], q_o[2][p], v_o[0][p]);
            end
         end
      end
   endtask
   initial begin
      for (int p = 0; p < 2; p++) begin
         en[p] = 1'b0;
         we[p] = 1'b0;
         ad[p] = '0;
         dt[p] = '0;
      end
      test_reset();
      test_clear();
      test_latency();
      test_rdw();
      test_cross();
      test_collision();
      test_random();
      test_reset_mid_clear();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
